// File: rtl/ddr5_phy_rd_burst_framer.sv
// Read-path burst framer: packs DRAM read beats into 8-beat bursts, drives the PHY CRC checker and releases bursts with a CRC verdict.
// Optional CRC path: define DDR5_PHY_RD_CRC_EN. Without it, bursts are plain 8-beat bursts.
module ddr5_phy_rd_burst_framer #(
  parameter int pDRAM_SIZE = 4,
  parameter int pALERT_LAT = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic                    phy_rddata_valid_i,
  input  logic [2*pDRAM_SIZE-1:0] phy_rddata_i,
  input  logic                    dfi_alert_n_i,
  output logic                    chk_pre_rddata_valid_o,
  output logic                    chk_crc_en_o,
  output logic [2*pDRAM_SIZE-1:0] chk_rddata_o,
  output logic                    dfi_rddata_valid_o,
  output logic [2*pDRAM_SIZE-1:0] dfi_rddata_o,
  output logic                    dfi_rddata_crc_err_o,
  output logic                    framing_err_o,
  output logic                    overflow_o,
  output logic [7:0]              crc_err_cnt_o
);
  localparam int W = 2*pDRAM_SIZE;

  typedef enum logic [2:0] {
    S_IDLE, S_DATA, S_CRC, S_WAIT, S_DRAIN
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] buf_q [8];
  logic [W-1:0] buf_d [8];
  logic [2:0]   wr_idx_q, wr_idx_d;
  logic [2:0]   rd_idx_q, rd_idx_d;
  logic         framing_err_q, framing_err_d;
  logic         overflow_q, overflow_d;
  logic         out_tail;
  logic         last_wait;
  logic         start;
  logic         cap;

`ifdef DDR5_PHY_RD_CRC_EN
  logic [2:0]   wait_cnt_q, wait_cnt_d;
  logic         err_q, err_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         pre_q, pre_d;
  logic         en_q, en_d;
  logic [W-1:0] chk_q, chk_d;
  assign out_tail  = 1'b0;
  assign last_wait = (wait_cnt_q == 3'(pALERT_LAT));
`else
  // Output is registered here, so the burst still occupies
  // the framer for one cycle after its drain state ends.
  logic         dout_vld_q, dout_vld_d;
  logic [W-1:0] dout_q, dout_d;
  logic         unused_alert;
  assign unused_alert = dfi_alert_n_i;
  assign out_tail     = dout_vld_q;
  assign last_wait    = 1'b0;
`endif

  assign start = (state_q == S_IDLE) && phy_rddata_valid_i
               && !out_tail;
  assign cap   = start
               || ((state_q == S_DATA) && phy_rddata_valid_i);

  // State register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic: any valid gap mid-burst aborts to idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start) state_d = S_DATA;
      S_DATA: begin
        if (!phy_rddata_valid_i) state_d = S_IDLE;
`ifdef DDR5_PHY_RD_CRC_EN
        else if (wr_idx_q == 3'd7) state_d = S_CRC;
`else
        else if (wr_idx_q == 3'd7) state_d = S_DRAIN;
`endif
      end
      S_CRC:   state_d = phy_rddata_valid_i ? S_WAIT : S_IDLE;
      S_WAIT:  if (last_wait) state_d = S_DRAIN;
      S_DRAIN: if (rd_idx_q == 3'd7) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Burst buffer write/read pointers
  always_comb begin
    buf_d    = buf_q;
    wr_idx_d = wr_idx_q;
    rd_idx_d = rd_idx_q;
    if (cap) begin
      buf_d[wr_idx_q] = phy_rddata_i;
      wr_idx_d        = wr_idx_q + 3'd1;
    end
    if (state_d == S_IDLE) wr_idx_d = 3'd0;
    if (state_q == S_DRAIN) rd_idx_d = rd_idx_q + 3'd1;
  end

  // Status pulses, checker feed and CRC verdict
  always_comb begin
    framing_err_d = ((state_q == S_DATA) || (state_q == S_CRC))
                  && !phy_rddata_valid_i;
    overflow_d    = phy_rddata_valid_i
                  && ((state_q == S_WAIT) || (state_q == S_DRAIN)
                  || ((state_q == S_IDLE) && out_tail));
`ifdef DDR5_PHY_RD_CRC_EN
    pre_d      = start;
    en_d       = cap;
    chk_d      = (cap || ((state_q == S_CRC) && phy_rddata_valid_i))
               ? phy_rddata_i : '0;
    wait_cnt_d = (state_q == S_WAIT) ? wait_cnt_q + 3'd1 : 3'd0;
    err_d      = err_q;
    cnt_d      = cnt_q;
    if ((state_q == S_WAIT) && last_wait) begin
      err_d = ~dfi_alert_n_i;
      if (!dfi_alert_n_i && (cnt_q != 8'hFF)) cnt_d = cnt_q + 8'd1;
    end
`else
    dout_vld_d = (state_q == S_DRAIN);
    dout_d     = (state_q == S_DRAIN) ? buf_q[rd_idx_q] : '0;
`endif
  end

  // Datapath and status registers
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < 8; i++) buf_q[i] <= '0;
      wr_idx_q      <= 3'd0;
      rd_idx_q      <= 3'd0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef DDR5_PHY_RD_CRC_EN
      wait_cnt_q    <= 3'd0;
      err_q         <= 1'b0;
      cnt_q         <= 8'd0;
      pre_q         <= 1'b0;
      en_q          <= 1'b0;
      chk_q         <= '0;
`else
      dout_vld_q    <= 1'b0;
      dout_q        <= '0;
`endif
    end else begin
      buf_q         <= buf_d;
      wr_idx_q      <= wr_idx_d;
      rd_idx_q      <= rd_idx_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
`ifdef DDR5_PHY_RD_CRC_EN
      wait_cnt_q    <= wait_cnt_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      pre_q         <= pre_d;
      en_q          <= en_d;
      chk_q         <= chk_d;
`else
      dout_vld_q    <= dout_vld_d;
      dout_q        <= dout_d;
`endif
    end
  end

  assign framing_err_o = framing_err_q;
  assign overflow_o    = overflow_q;

`ifdef DDR5_PHY_RD_CRC_EN
  assign chk_pre_rddata_valid_o = pre_q;
  assign chk_crc_en_o           = en_q;
  assign chk_rddata_o           = chk_q;
  assign dfi_rddata_valid_o     = (state_q == S_DRAIN);
  assign dfi_rddata_o           = (state_q == S_DRAIN)
                                ? buf_q[rd_idx_q] : '0;
  assign dfi_rddata_crc_err_o   = (state_q == S_DRAIN) && err_q;
  assign crc_err_cnt_o          = cnt_q;
`else
  assign chk_pre_rddata_valid_o = 1'b0;
  assign chk_crc_en_o           = 1'b0;
  assign chk_rddata_o           = '0;
  assign dfi_rddata_valid_o     = dout_vld_q;
  assign dfi_rddata_o           = dout_q;
  assign dfi_rddata_crc_err_o   = 1'b0;
  assign crc_err_cnt_o          = 8'd0;
`endif

endmodule

// File: tb/tb_ddr5_phy_rd_burst_framer.sv
// Bench for ddr5_phy_rd_burst_framer: per-cycle outputs compared
// against a burst-timeline reference model.
module tb_ddr5_phy_rd_burst_framer;
  localparam int DS   = 4;
  localparam int W    = 2*DS;
  localparam int LAT  = 1;
  localparam int MAXC = 6000;
  localparam int AW   = MAXC + 64;
  localparam int PW   = 2*W + 14;
  localparam int B_EN  = 8 + W;
  localparam int B_PRE = 9 + W;
  localparam int B_OV  = 10 + W;
  localparam int B_FR  = 11 + W;
  localparam int B_ERR = 12 + W;
  localparam int B_DAT = 13 + W;
  localparam int B_VLD = 13 + 2*W;
`ifdef DDR5_PHY_RD_CRC_EN
  localparam bit CRC = 1'b1;
`else
  localparam bit CRC = 1'b0;
`endif
  localparam int NB  = CRC ? 9 : 8;
  localparam int PER = CRC ? 18 + LAT : 17;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         vld_i = 1'b0;
  logic [W-1:0] dat_i = '0;
  logic         al_i = 1'b1;
  logic         pre_o, en_o, dvld_o, derr_o, fr_o, ov_o;
  logic [W-1:0] chk_o, ddat_o;
  logic [7:0]   cnt_o;

  int n_chk = 0;
  int n_pass = 0;

  bit           s_vld [AW];
  logic [W-1:0] s_dat [AW];
  bit           s_al  [AW];
  logic [PW-1:0] exp_v [AW];
  logic [PW-1:0] obs_v [AW];
  bit           e_vld [AW];
  logic [W-1:0] e_dat [AW];
  bit           e_err [AW];
  bit           e_fr  [AW];
  bit           e_ov  [AW];
  bit           e_pre [AW];
  bit           e_en  [AW];
  logic [W-1:0] e_chk [AW];
  bit           e_inc [AW];

  ddr5_phy_rd_burst_framer #(
    .pDRAM_SIZE(DS),
    .pALERT_LAT(LAT)
  ) dut (
    .clk_i                 (clk),
    .rst_n_i               (rst_n),
    .phy_rddata_valid_i    (vld_i),
    .phy_rddata_i          (dat_i),
    .dfi_alert_n_i         (al_i),
    .chk_pre_rddata_valid_o(pre_o),
    .chk_crc_en_o          (en_o),
    .chk_rddata_o          (chk_o),
    .dfi_rddata_valid_o    (dvld_o),
    .dfi_rddata_o          (ddat_o),
    .dfi_rddata_crc_err_o  (derr_o),
    .framing_err_o         (fr_o),
    .overflow_o            (ov_o),
    .crc_err_cnt_o         (cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [PW-1:0] pack();
    return {dvld_o, ddat_o, derr_o, fr_o, ov_o,
            pre_o, en_o, chk_o, cnt_o};
  endfunction

  task automatic clear_stim();
    for (int c = 0; c < AW; c++) begin
      s_vld[c] = 1'b0;
      s_dat[c] = '0;
      s_al[c]  = 1'b1;
    end
  endtask

  // nb beats from c0; data 1..n (CRC beat 0xAA) or random
  task automatic put_burst(input int c0, input int nb,
                           input bit rnd);
    for (int k = 0; k < nb; k++) begin
      s_vld[c0+k] = 1'b1;
      if (rnd) s_dat[c0+k] = W'($urandom);
      else s_dat[c0+k] = (k == 8) ? W'(8'hAA) : W'(k+1);
    end
  endtask

  task automatic do_reset();
    vld_i = 1'b0;
    dat_i = '0;
    al_i  = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Burst-level view: a burst starts on a valid beat when free,
  // needs NB consecutive beats, then outputs a fixed time later;
  // beats while it is pending/draining are overflows.
  task automatic model(input int n);
    int c, c0, g, last, o, ws, we, cnt;
    bit err;
    for (int t = 0; t < AW; t++) begin
      e_vld[t] = 0; e_dat[t] = '0; e_err[t] = 0; e_fr[t] = 0;
      e_ov[t] = 0; e_pre[t] = 0; e_en[t] = 0; e_chk[t] = '0;
      e_inc[t] = 0;
    end
    c = 0;
    while (c < n) begin
      if (!s_vld[c]) begin
        c++;
      end else begin
        c0 = c;
        g  = -1;
        for (int k = 0; k < NB; k++)
          if (g < 0 && !s_vld[c0+k]) g = c0 + k;
        last = (g < 0) ? c0 + NB - 1 : g - 1;
        if (CRC)
          for (int t = c0; t <= last; t++) begin
            e_chk[t+1] = s_dat[t];
            e_en[t+1]  = (t < c0 + 8);
            e_pre[t+1] = (t == c0);
          end
        if (g >= 0) begin
          e_fr[g+1] = 1'b1;
          c = g + 1;
        end else begin
          o   = CRC ? c0 + 10 + LAT : c0 + 9;
          err = CRC ? !s_al[c0+9+LAT] : 1'b0;
          for (int k = 0; k < 8; k++) begin
            e_vld[o+k] = 1'b1;
            e_dat[o+k] = s_dat[c0+k];
            e_err[o+k] = err;
          end
          e_inc[o] = err;
          ws = CRC ? c0 + 9 : c0 + 8;
          we = o + 7;
          for (int t = ws; t <= we; t++)
            if (s_vld[t]) e_ov[t+1] = 1'b1;
          c = we + 1;
        end
      end
    end
    cnt = 0;
    for (int t = 0; t <= n; t++) begin
      if (e_inc[t] && cnt < 255) cnt++;
      exp_v[t] = {e_vld[t], e_dat[t], e_err[t], e_fr[t], e_ov[t],
                  e_pre[t], e_en[t], e_chk[t], 8'(cnt)};
    end
  endtask

  // Drive stimulus cycles 0..n-1, record outputs of cycles 0..n
  task automatic run(input int n);
    obs_v[0] = pack();
    for (int c = 0; c < n; c++) begin
      vld_i = s_vld[c];
      dat_i = s_dat[c];
      al_i  = s_al[c];
      @(posedge clk);
      #1;
      obs_v[c+1] = pack();
    end
    vld_i = 1'b0;
    dat_i = '0;
    al_i  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vld_i = 1'b1;
    dat_i = W'(8'h5A);
    @(posedge clk);
    #1;
    n_chk++;
    if (pack() !== '0)
      $display("FAIL reset_hold: got %h want 0", pack());
    else n_pass++;
    do_reset();
    n_chk++;
    if (pack() !== '0)
      $display("FAIL reset_release: got %h want 0", pack());
    else n_pass++;
  endtask

  task automatic test_good_burst();
    int n, c0, oc;
    c0 = 2; n = 40;
    clear_stim();
    put_burst(c0, NB, 1'b0);
    do_reset();
    model(n);
    run(n);
    for (int c = 0; c <= n; c++) begin
      n_chk++;
      if (obs_v[c] !== exp_v[c])
        $display("FAIL good_burst cyc %0d: got %h want %h",
                 c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
    oc = CRC ? c0 + 10 + LAT : c0 + 9;
    n_chk++;
    if ({obs_v[oc][B_VLD], obs_v[oc][B_DAT +: W]} !== {1'b1, W'(1)})
      $display("FAIL good_first_out: got %h want %h",
               {obs_v[oc][B_VLD], obs_v[oc][B_DAT +: W]},
               {1'b1, W'(1)});
    else n_pass++;
  endtask

  task automatic test_bad_burst();
    int n, c0, oc;
    c0 = 3; n = 40;
    clear_stim();
    put_burst(c0, NB, 1'b0);
    s_al[c0+9+LAT] = 1'b0;
    do_reset();
    model(n);
    run(n);
    for (int c = 0; c <= n; c++) begin
      n_chk++;
      if (obs_v[c] !== exp_v[c])
        $display("FAIL bad_burst cyc %0d: got %h want %h",
                 c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
    oc = CRC ? c0 + 10 + LAT : c0 + 9;
    n_chk++;
    if ({obs_v[oc][B_ERR], obs_v[oc][7:0]} !== {CRC, 8'(CRC)})
      $display("FAIL bad_err_cnt: got %h want %h",
               {obs_v[oc][B_ERR], obs_v[oc][7:0]}, {CRC, 8'(CRC)});
    else n_pass++;
  endtask

  task automatic test_framing();
    int n, c0, nv;
    c0 = 2; n = 50;
    clear_stim();
    put_burst(c0, 5, 1'b1);
    put_burst(c0 + 7, NB, 1'b1);
    do_reset();
    model(n);
    run(n);
    for (int c = 0; c <= n; c++) begin
      n_chk++;
      if (obs_v[c] !== exp_v[c])
        $display("FAIL framing cyc %0d: got %h want %h",
                 c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
    n_chk++;
    if (obs_v[c0+6][B_FR] !== 1'b1)
      $display("FAIL framing_pulse: got %b want 1",
               obs_v[c0+6][B_FR]);
    else n_pass++;
    nv = 0;
    for (int c = 0; c <= n; c++) nv += int'(obs_v[c][B_VLD]);
    n_chk++;
    if (nv !== 8)
      $display("FAIL framing_out_beats: got %0d want 8", nv);
    else n_pass++;
  endtask

  task automatic test_overflow();
    int n, c0, nov;
    c0 = 1; n = 45;
    clear_stim();
    put_burst(c0, NB, 1'b1);
    if (CRC) begin
      s_vld[c0+10] = 1'b1;
      s_vld[c0+12] = 1'b1;
      s_vld[c0+14] = 1'b1;
      s_vld[c0+18] = 1'b1;
    end else begin
      s_vld[c0+9]  = 1'b1;
      s_vld[c0+11] = 1'b1;
      s_vld[c0+13] = 1'b1;
      s_vld[c0+16] = 1'b1;
    end
    do_reset();
    model(n);
    run(n);
    for (int c = 0; c <= n; c++) begin
      n_chk++;
      if (obs_v[c] !== exp_v[c])
        $display("FAIL overflow cyc %0d: got %h want %h",
                 c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
    nov = 0;
    for (int c = 0; c <= n; c++) nov += int'(obs_v[c][B_OV]);
    n_chk++;
    if (nov !== 4)
      $display("FAIL overflow_pulses: got %0d want 4", nov);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int n;
    n = 6 + 4*PER + 25;
    clear_stim();
    for (int i = 0; i < 4; i++) put_burst(5 + i*PER, NB, 1'b1);
    for (int c = 0; c < n; c++) s_al[c] = ($urandom_range(0, 1) == 1);
    do_reset();
    model(n);
    run(n);
    for (int c = 0; c <= n; c++) begin
      n_chk++;
      if (obs_v[c] !== exp_v[c])
        $display("FAIL back_to_back cyc %0d: got %h want %h",
                 c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int n, c, len;
    for (int it = 0; it < 4; it++) begin
      n = 1500;
      clear_stim();
      c = 2;
      while (c < n - 40) begin
        if ($urandom_range(0, 3) == 0) len = $urandom_range(1, NB - 1);
        else len = NB;
        put_burst(c, len, 1'b1);
        c += len + $urandom_range(0, 24);
      end
      for (int t = 0; t < n; t++) s_al[t] = ($urandom_range(0, 3) != 0);
      do_reset();
      model(n);
      run(n);
      for (int t = 0; t <= n; t++) begin
        n_chk++;
        if (obs_v[t] !== exp_v[t])
          $display("FAIL random it%0d cyc %0d: got %h want %h",
                   it, t, obs_v[t], exp_v[t]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_saturation();
    int n;
    n = 1 + 260*PER + 25;
    clear_stim();
    for (int i = 0; i < 260; i++) put_burst(1 + i*PER, NB, 1'b1);
    for (int c = 0; c < n; c++) s_al[c] = 1'b0;
    do_reset();
    model(n);
    run(n);
    for (int c = 0; c <= n; c++) begin
      n_chk++;
      if (obs_v[c] !== exp_v[c])
        $display("FAIL saturation cyc %0d: got %h want %h",
                 c, obs_v[c], exp_v[c]);
      else n_pass++;
    end
    n_chk++;
    if (cnt_o !== (CRC ? 8'd255 : 8'd0))
      $display("FAIL sat_count: got %0d want %0d",
               cnt_o, CRC ? 255 : 0);
    else n_pass++;
    // Second round without reset: reset lands mid-data
    for (int k = 0; k < 4; k++) begin
      vld_i = 1'b1;
      dat_i = W'($urandom);
      @(posedge clk);
      #1;
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (pack() !== '0)
      $display("FAIL async_rst_data: got %h want 0", pack());
    else n_pass++;
    vld_i = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (pack() !== '0)
        $display("FAIL async_abort cyc %0d: got %h want 0", k, pack());
      else n_pass++;
    end
  endtask

  task automatic test_async_reset_drain();
    int oc;
    clear_stim();
    put_burst(1, NB, 1'b1);
    oc = CRC ? 11 + LAT : 10;
    do_reset();
    run(oc + 2);
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (pack() !== '0)
      $display("FAIL async_rst_drain: got %h want 0", pack());
    else n_pass++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      n_chk++;
      if (pack() !== '0)
        $display("FAIL drain_abort cyc %0d: got %h want 0", k, pack());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_good_burst();
    test_bad_burst();
    test_framing();
    test_overflow();
    test_back_to_back();
    test_random();
    test_saturation();
    test_async_reset_drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
